// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//
// Issue/writeback controller that sits in front of the multi-cycle multiplier
// and divider in the execute stage. It captures one request from decode,
// drives held operands and a one-cycle start pulse to the selected unit,
// stalls the pipeline while the unit works, and produces exactly one
// writeback. The writeback carries either the unit result to the destination
// register or an exception code to the status register.
//
// Cycle view of one operation (cycle 0 = start sampled in IDLE):
//   1      ISSUE : ctrl pulse, stall rises
//   2      WAIT  : first wait cycle, rdy ignored (may be left over from the
//                  previous operation)
//   k>=3   WAIT  : rdy seen -> WB in k+1, IDLE in k+2
//   TIMEOUT+2    : timeout writeback if rdy never arrives
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int TIMEOUT    = 48,
    parameter int STATUS_REG = 30,
    parameter int MULT_EXC   = 1,
    parameter int DIV_EXC    = 2,
    parameter int TO_EXC     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  dest,
    input  logic [31:0] mult_result,
    input  logic        mult_exception,
    input  logic        mult_rdy,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    input  logic        div_rdy,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } stateT;

    // The wait counter is 6 bits and saturates at its maximum value.
    localparam logic [5:0] CNT_MAX      = 6'h3F;
    // Value of the counter during the last WAIT cycle before a timeout.
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
    localparam logic [4:0] STATUS_IDX   = 5'(STATUS_REG);
    localparam logic [31:0] MULT_CODE   = 32'(MULT_EXC);
    localparam logic [31:0] DIV_CODE    = 32'(DIV_EXC);
    localparam logic [31:0] TO_CODE     = 32'(TO_EXC);

    stateT       state;
    logic [31:0] opAHold;
    logic [31:0] opBHold;
    logic [4:0]  destHold;
    logic        isDiv;
    logic [5:0]  waitCnt;
    logic        ctrlMultQ;
    logic        ctrlDivQ;
    logic        stallQ;
    logic        wbValidQ;
    logic [4:0]  wbRegQ;
    logic [31:0] wbDataQ;

    // Signals from the unit selected for the in-flight operation.
    logic        selRdy;
    logic [31:0] selResult;
    logic        selExc;
    logic [31:0] selExcCode;
    logic        rdyEligible;
    logic        timeoutHit;
    logic [5:0]  cntNext;

    // Select the active unit's handshake and derive the WAIT-state decisions.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        selRdy     = mult_rdy;
        selResult  = mult_result;
        selExc     = mult_exception;
        selExcCode = MULT_CODE;
        if (isDiv) begin
            selRdy     = div_rdy;
            selResult  = div_result;
            selExc     = div_exception;
            selExcCode = DIV_CODE;
        end
        // The counter is zero only in the first WAIT cycle, where a rdy still
        // high from the previous operation must not be mistaken for ours.
        rdyEligible = (waitCnt != 6'd0);
        timeoutHit  = (waitCnt == TIMEOUT_LAST);
        cntNext     = (waitCnt == CNT_MAX) ? waitCnt : waitCnt + 6'd1;
    end

    // Controller state, operand hold registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            opAHold   <= '0;
            opBHold   <= '0;
            destHold  <= '0;
            isDiv     <= 1'b0;
            waitCnt   <= '0;
            ctrlMultQ <= 1'b0;
            ctrlDivQ  <= 1'b0;
            stallQ    <= 1'b0;
            wbValidQ  <= 1'b0;
            wbRegQ    <= '0;
            wbDataQ   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here sees the values from before this clock edge.
            // Pulses default low and are raised only on the cycle they apply.
            ctrlMultQ <= 1'b0;
            ctrlDivQ  <= 1'b0;
            wbValidQ  <= 1'b0;

            unique case (state)
                IDLE: begin
                    // flush outranks a start: the request is simply dropped.
                    if (!flush && (start_mult || start_div)) begin
                        opAHold   <= op_a;
                        opBHold   <= op_b;
                        destHold  <= dest;
                        // Both starts together is illegal; multiply wins.
                        isDiv     <= !start_mult;
                        ctrlMultQ <= start_mult;
                        ctrlDivQ  <= !start_mult;
                        stallQ    <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (flush) begin
                        stallQ <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        waitCnt <= '0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (flush) begin
                        // Abandon the operation; a late result is never written.
                        stallQ <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        waitCnt <= cntNext;
                        if (rdyEligible && selRdy) begin
                            state <= WB;
                            if (selExc) begin
                                wbValidQ <= 1'b1;
                                wbRegQ   <= STATUS_IDX;
                                wbDataQ  <= selExcCode;
                            end else begin
                                // A result destined for r0 is discarded.
                                wbValidQ <= (destHold != 5'd0);
                                wbRegQ   <= destHold;
                                wbDataQ  <= selResult;
                            end
                        end else if (timeoutHit) begin
                            state    <= WB;
                            wbValidQ <= 1'b1;
                            wbRegQ   <= STATUS_IDX;
                            wbDataQ  <= TO_CODE;
                        end
                    end
                end

                WB: begin
                    // Writeback lasts one cycle whether or not flush is high.
                    stallQ <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    stallQ <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Operands come straight from the hold registers, so they stay stable
    // while the divider latches them transparently during ctrl_DIV.
    assign data_operandA = opAHold;
    assign data_operandB = opBHold;
    assign stall         = stallQ;
    assign wb_reg        = wbRegQ;
    assign wb_data       = wbDataQ;

    // flush must kill a pulse or strobe that is already on the wires in the
    // current cycle, so the registered values are gated here.
    assign ctrl_MULT = ctrlMultQ && !flush;
    assign ctrl_DIV  = ctrlDivQ && !flush;
    assign wb_valid  = wbValidQ && !flush;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Directed bench for multdiv_ctrl. A cycle-stepping driver applies one
// operation with a behavioural unit model (rdy raised at a chosen cycle and
// then held, as the real units do) and records what it observed; each test
// task compares those observations against hand-computed values.
// Cycle 0 is the cycle in which the start request is presented.
// ---------------------------------------------------------------------------
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_rdy;
    logic [31:0] div_result;
    logic        div_exception;
    logic        div_rdy;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int nVec = 0;
    int nMis = 0;

    // Observations gathered by run_op.
    int          obsStall0;
    int          obsStallFirst;
    int          obsStallLast;
    int          obsStallN;
    int          obsCtrlMN;
    int          obsCtrlDN;
    int          obsCtrlCyc;
    int          obsWbN;
    int          obsWbCyc;
    logic [4:0]  obsWbReg;
    logic [31:0] obsWbData;
    int          obsOpsBad;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start_mult     (start_mult),
        .start_div      (start_div),
        .flush          (flush),
        .op_a           (op_a),
        .op_b           (op_b),
        .dest           (dest),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_rdy       (mult_rdy),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .div_rdy        (div_rdy),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case anything ever stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive one operation for cycles 0..endCyc and record what the DUT did.
    // rdyCyc = first cycle the unit raises rdy (0 = never); rdy then stays up.
    // stale  = rdy left high from a previous op during cycles 0..2.
    // flushCyc = cycle in which flush is high (-1 = none).
    // holdStart = last cycle in which the start request is still asserted.
    task automatic run_op(input logic isMult, input logic isDivReq,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int rdyCyc,
                          input logic [31:0] res, input logic exc,
                          input logic stale, input int flushCyc,
                          input int holdStart, input int endCyc);
        logic rdyNow;
        obsStall0     = -1;
        obsStallFirst = -1;
        obsStallLast  = -1;
        obsStallN     = 0;
        obsCtrlMN     = 0;
        obsCtrlDN     = 0;
        obsCtrlCyc    = -1;
        obsWbN        = 0;
        obsWbCyc      = -1;
        obsWbReg      = '0;
        obsWbData     = '0;
        obsOpsBad     = 0;
        for (int c = 0; c <= endCyc; c++) begin
            @(posedge clock);
            #1;
            start_mult     = (c <= holdStart) ? isMult : 1'b0;
            start_div      = (c <= holdStart) ? isDivReq : 1'b0;
            op_a           = a;
            op_b           = b;
            dest           = d;
            flush          = (c == flushCyc);
            rdyNow         = ((rdyCyc > 0) && (c >= rdyCyc)) || (stale && (c <= 2));
            mult_rdy       = isMult && rdyNow;
            div_rdy        = !isMult && rdyNow;
            mult_result    = res;
            div_result     = res;
            mult_exception = exc;
            div_exception  = exc;
            #1;
            if (c == 0) begin
                obsStall0 = int'(stall);
            end else begin
                if (stall) begin
                    if (obsStallFirst < 0) obsStallFirst = c;
                    obsStallLast = c;
                    obsStallN++;
                end
                if (ctrl_MULT) begin
                    obsCtrlMN++;
                    obsCtrlCyc = c;
                end
                if (ctrl_DIV) begin
                    obsCtrlDN++;
                    obsCtrlCyc = c;
                end
                if (wb_valid) begin
                    obsWbN++;
                    obsWbCyc  = c;
                    obsWbReg  = wb_reg;
                    obsWbData = wb_data;
                end
                if ((data_operandA !== a) || (data_operandB !== b)) obsOpsBad = 1;
            end
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_mult = 0; start_div = 0; flush = 0;
        op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; dest = 5'd3;
        mult_result = 0; mult_exception = 0; mult_rdy = 0;
        div_result = 0; div_exception = 0; div_rdy = 0;
        #1;
        nVec++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_valid} !== 4'b0000) begin
            nMis++;
            $display("FAIL reset_ctrl: got {mult,div,stall,wbv}=%b want 0000",
                     {ctrl_MULT, ctrl_DIV, stall, wb_valid});
        end
        nVec++;
        if ({wb_reg, wb_data} !== 37'd0) begin
            nMis++;
            $display("FAIL reset_wb: got reg=%0d data=%h want 0/0", wb_reg, wb_data);
        end
        nVec++;
        if ({data_operandA, data_operandB} !== 64'd0) begin
            nMis++;
            $display("FAIL reset_operands: got A=%h B=%h want 0/0", data_operandA, data_operandB);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_divide();
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 34, 32'd14, 1'b0, 1'b0, -1, 0, 40);
        nVec++;
        if (obsCtrlDN !== 1 || obsCtrlCyc !== 1) begin
            nMis++;
            $display("FAIL div_pulse: got count=%0d cycle=%0d want 1/1", obsCtrlDN, obsCtrlCyc);
        end
        nVec++;
        if (obsCtrlMN !== 0) begin
            nMis++;
            $display("FAIL div_no_mult: got ctrl_MULT count=%0d want 0", obsCtrlMN);
        end
        nVec++;
        if (obsStallFirst !== 1 || obsStallLast !== 35 || obsStallN !== 35) begin
            nMis++;
            $display("FAIL div_stall: got first=%0d last=%0d n=%0d want 1/35/35",
                     obsStallFirst, obsStallLast, obsStallN);
        end
        nVec++;
        if (obsWbN !== 1 || obsWbCyc !== 35) begin
            nMis++;
            $display("FAIL div_wb_timing: got n=%0d cycle=%0d want 1/35", obsWbN, obsWbCyc);
        end
        nVec++;
        if (obsWbReg !== 5'd5 || obsWbData !== 32'd14) begin
            nMis++;
            $display("FAIL div_wb_value: got reg=%0d data=%0d want 5/14", obsWbReg, obsWbData);
        end
        nVec++;
        if (obsOpsBad !== 0) begin
            nMis++;
            $display("FAIL div_operands: got unstable=%0d want 0", obsOpsBad);
        end
    endtask

    task automatic test_div_by_zero();
        run_op(1'b0, 1'b1, 32'd100, 32'd0, 5'd5, 34, 32'd0, 1'b1, 1'b0, -1, 0, 38);
        nVec++;
        if (obsWbN !== 1 || obsWbCyc !== 35) begin
            nMis++;
            $display("FAIL divz_wb_timing: got n=%0d cycle=%0d want 1/35", obsWbN, obsWbCyc);
        end
        nVec++;
        if (obsWbReg !== 5'd30 || obsWbData !== 32'd2) begin
            nMis++;
            $display("FAIL divz_wb_value: got reg=%0d data=%0d want 30/2", obsWbReg, obsWbData);
        end
    endtask

    task automatic test_multiply();
        run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4, 5'd7, 6, 32'hFFFF_FFF4, 1'b0, 1'b0, -1, 0, 10);
        nVec++;
        if (obsCtrlMN !== 1 || obsCtrlCyc !== 1 || obsCtrlDN !== 0) begin
            nMis++;
            $display("FAIL mult_pulse: got mult=%0d div=%0d cycle=%0d want 1/0/1",
                     obsCtrlMN, obsCtrlDN, obsCtrlCyc);
        end
        nVec++;
        if (obsWbN !== 1 || obsWbCyc !== 7 || obsWbReg !== 5'd7 || obsWbData !== 32'hFFFF_FFF4) begin
            nMis++;
            $display("FAIL mult_wb: got n=%0d cyc=%0d reg=%0d data=%h want 1/7/7/fffffff4",
                     obsWbN, obsWbCyc, obsWbReg, obsWbData);
        end
        run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4, 5'd7, 6, 32'hFFFF_FFF4, 1'b1, 1'b0, -1, 0, 10);
        nVec++;
        if (obsWbN !== 1 || obsWbReg !== 5'd30 || obsWbData !== 32'd1) begin
            nMis++;
            $display("FAIL mult_exc: got n=%0d reg=%0d data=%0d want 1/30/1",
                     obsWbN, obsWbReg, obsWbData);
        end
    endtask

    task automatic test_stale_timeout();
        run_op(1'b0, 1'b1, 32'd81, 32'd9, 5'd6, 0, 32'd9, 1'b0, 1'b1, -1, 0, 55);
        nVec++;
        if (obsWbN !== 1 || obsWbCyc !== 50) begin
            nMis++;
            $display("FAIL timeout_timing: got n=%0d cycle=%0d want 1/50", obsWbN, obsWbCyc);
        end
        nVec++;
        if (obsWbReg !== 5'd30 || obsWbData !== 32'd3) begin
            nMis++;
            $display("FAIL timeout_value: got reg=%0d data=%0d want 30/3", obsWbReg, obsWbData);
        end
        nVec++;
        if (obsStallLast !== 50 || obsStallN !== 50) begin
            nMis++;
            $display("FAIL timeout_stall: got last=%0d n=%0d want 50/50", obsStallLast, obsStallN);
        end
    endtask

    task automatic test_flush();
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 34, 32'd14, 1'b0, 1'b0, 10, 0, 40);
        nVec++;
        if (obsWbN !== 0) begin
            nMis++;
            $display("FAIL flush_no_wb: got wb_valid count=%0d want 0", obsWbN);
        end
        nVec++;
        if (obsStallLast !== 10 || obsStallN !== 10) begin
            nMis++;
            $display("FAIL flush_stall: got last=%0d n=%0d want 10/10", obsStallLast, obsStallN);
        end
        // flush together with a start in IDLE drops the request.
        run_op(1'b1, 1'b0, 32'd3, 32'd3, 5'd4, 3, 32'd9, 1'b0, 1'b0, 0, 0, 8);
        nVec++;
        if (obsStallN !== 0 || obsCtrlMN !== 0 || obsWbN !== 0) begin
            nMis++;
            $display("FAIL flush_idle: got stall=%0d ctrl=%0d wb=%0d want 0/0/0",
                     obsStallN, obsCtrlMN, obsWbN);
        end
    endtask

    task automatic test_reset_mid_op();
        @(posedge clock);
        #1;
        start_div = 1'b1; op_a = 32'd77; op_b = 32'd11; dest = 5'd4;
        div_rdy = 1'b0; mult_rdy = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            #1;
            start_div = 1'b0;
        end
        #1;
        nVec++;
        if (stall !== 1'b1) begin
            nMis++;
            $display("FAIL rst_mid_pre: got stall=%b want 1", stall);
        end
        reset = 1'b0;
        #1;
        nVec++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_reg, wb_data, data_operandA, data_operandB} !== '0) begin
            nMis++;
            $display("FAIL rst_mid_zero: got stall=%b wbv=%b reg=%0d data=%h A=%h B=%h want all 0",
                     stall, wb_valid, wb_reg, wb_data, data_operandA, data_operandB);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        run_op(1'b1, 1'b0, 32'd5, 32'd6, 5'd8, 4, 32'd30, 1'b0, 1'b0, -1, 0, 7);
        nVec++;
        if (obsCtrlCyc !== 1 || obsWbCyc !== 5 || obsWbReg !== 5'd8 || obsWbData !== 32'd30) begin
            nMis++;
            $display("FAIL rst_mid_after: got ctrl=%0d wbcyc=%0d reg=%0d data=%0d want 1/5/8/30",
                     obsCtrlCyc, obsWbCyc, obsWbReg, obsWbData);
        end
    endtask

    task automatic test_dest_zero_and_starts();
        run_op(1'b1, 1'b0, 32'd2, 32'd3, 5'd0, 5, 32'd6, 1'b0, 1'b0, -1, 0, 9);
        nVec++;
        if (obsWbN !== 0 || obsStallLast !== 6 || obsStallN !== 6) begin
            nMis++;
            $display("FAIL dest0: got wb=%0d last=%0d n=%0d want 0/6/6",
                     obsWbN, obsStallLast, obsStallN);
        end
        run_op(1'b1, 1'b1, 32'd10, 32'd20, 5'd9, 4, 32'd200, 1'b0, 1'b0, -1, 0, 7);
        nVec++;
        if (obsCtrlMN !== 1 || obsCtrlDN !== 0) begin
            nMis++;
            $display("FAIL both_starts_pulse: got mult=%0d div=%0d want 1/0", obsCtrlMN, obsCtrlDN);
        end
        nVec++;
        if (obsWbCyc !== 5 || obsWbReg !== 5'd9 || obsWbData !== 32'd200) begin
            nMis++;
            $display("FAIL both_starts_wb: got cyc=%0d reg=%0d data=%0d want 5/9/200",
                     obsWbCyc, obsWbReg, obsWbData);
        end
        // Start held high for the whole busy period must not re-issue.
        run_op(1'b0, 1'b1, 32'd50, 32'd5, 5'd3, 10, 32'd10, 1'b0, 1'b0, -1, 11, 15);
        nVec++;
        if (obsCtrlDN !== 1 || obsWbN !== 1 || obsStallN !== 11) begin
            nMis++;
            $display("FAIL start_during_stall: got ctrl=%0d wb=%0d stall=%0d want 1/1/11",
                     obsCtrlDN, obsWbN, obsStallN);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd1, 4, 32'd42, 1'b0, 1'b0, -1, 0, 5);
        nVec++;
        if (obsWbCyc !== 5 || obsWbReg !== 5'd1 || obsWbData !== 32'd42) begin
            nMis++;
            $display("FAIL b2b_first: got cyc=%0d reg=%0d data=%0d want 5/1/42",
                     obsWbCyc, obsWbReg, obsWbData);
        end
        // Second request lands in the first IDLE cycle after WB.
        run_op(1'b0, 1'b1, 32'd9, 32'd3, 5'd2, 5, 32'd3, 1'b0, 1'b0, -1, 0, 9);
        nVec++;
        if (obsStall0 !== 0 || obsCtrlDN !== 1 || obsCtrlCyc !== 1) begin
            nMis++;
            $display("FAIL b2b_accept: got stall0=%0d ctrl=%0d cyc=%0d want 0/1/1",
                     obsStall0, obsCtrlDN, obsCtrlCyc);
        end
        nVec++;
        if (obsWbCyc !== 6 || obsWbReg !== 5'd2 || obsWbData !== 32'd3) begin
            nMis++;
            $display("FAIL b2b_second: got cyc=%0d reg=%0d data=%0d want 6/2/3",
                     obsWbCyc, obsWbReg, obsWbData);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_by_zero();
        test_multiply();
        test_stale_timeout();
        test_flush();
        test_reset_mid_op();
        test_dest_zero_and_starts();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Issue/writeback controller directly upstream of the multi-cycle divider and multiplier in the processor's execute stage. Captures a mult or div request from decode, drives the unit's operands and its one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, and stalls the pipeline until the unit reports ready. It then returns one writeback: the result to the destination register, or an error code to the status register.

## Interface
- `TIMEOUT`, 48: WAIT cycles allowed before the operation is abandoned.
- `STATUS_REG`, 30: register index written on any exception.
- `MULT_EXC`, 1: status code for a multiply exception.
- `DIV_EXC`, 2: status code for a divide exception.
- `TO_EXC`, 3: status code for a timeout.
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `start_mult`  input  1  decode requests a multiply; sampled in IDLE only.
- `start_div`  input  1  decode requests a divide; sampled in IDLE only.
- `flush`  input  1  abort any in-flight operation, with no writeback.
- `op_a`  input  32  operand A (dividend or multiplicand).
- `op_b`  input  32  operand B (divisor or multiplier).
- `dest`  input  5  destination register index.
- `mult_result`  input  32  multiplier result.
- `mult_exception`  input  1  multiplier exception flag.
- `mult_rdy`  input  1  multiplier result-ready flag.
- `div_result`  input  32  divider result.
- `div_exception`  input  1  divider exception flag.
- `div_rdy`  input  1  divider result-ready flag.
- `data_operandA`  output  32  held operand A to both units.
- `data_operandB`  output  32  held operand B to both units.
- `ctrl_MULT`  output  1  registered one-cycle start pulse to the multiplier.
- `ctrl_DIV`  output  1  registered one-cycle start pulse to the divider.
- `stall`  output  1  freeze the upstream pipeline latches.
- `wb_valid`  output  1  one-cycle register-file write strobe.
- `wb_reg`  output  5  writeback register index.
- `wb_data`  output  32  writeback value.

## Operation
- States: IDLE → ISSUE → WAIT → WB → IDLE. A 2-bit encoding is sufficient.
- **IDLE**
  - If `start_mult` or `start_div` is high, latch `op_a`, `op_b`, `dest` and the op type, then go to ISSUE.
  - If both starts are high, the multiply wins; this is an illegal combination from decode.
- **ISSUE** (one cycle)
  - The selected ctrl output is 1. The other ctrl output stays 0.
  - Clear the wait counter and go to WAIT.
- **WAIT**
  - The wait counter increments every cycle.
  - The selected unit's rdy is ignored in the first WAIT cycle, because rdy from the previous op may still be high until the unit's counter clears.
  - From the second WAIT cycle on, when the selected rdy is 1: capture its result and exception flag, then go to WB.
  - If the counter reaches `TIMEOUT` without rdy: force exception code `TO_EXC`, then go to WB.
- **WB** (one cycle)
  - `wb_valid` = 1.
  - With no exception: `wb_reg` = latched `dest`, `wb_data` = captured result.
  - With an exception: `wb_reg` = `STATUS_REG`, `wb_data` = `MULT_EXC` or `DIV_EXC` or `TO_EXC`, zero-extended.
  - If there is no exception and `dest` = 0, then `wb_valid` = 0.
  - Return to IDLE.
- `data_operandA`/`data_operandB` are driven from the hold registers. They are stable from ISSUE through WB and keep their last value in IDLE. This matters because the divider latches operands transparently while `ctrl_DIV` is high.
- `stall` = 1 whenever state ≠ IDLE. It is registered, so it is never combinational from the start inputs.
- Start inputs are ignored in every state other than IDLE.
- `flush` in ISSUE, WAIT or WB sends the state to IDLE at the next edge.
  - A pending or current `wb_valid` is suppressed.
  - `ctrl_*` is forced to 0.
  - The unit's late result is never written.
- `flush` in IDLE has priority over start: the request is dropped.
- Reset (`reset` = 0), at any time, immediately forces all of the following:
  - state = IDLE;
  - `ctrl_MULT` = `ctrl_DIV` = `stall` = `wb_valid` = 0;
  - `wb_reg` = 0, `wb_data` = 0;
  - operand hold registers = 0;
  - wait counter = 0.
- The counter is 6 bits wide and saturates. It never wraps.

## Timing
- Cycle 0: start is sampled in IDLE.
- Cycle 1: ISSUE; `ctrl_*` = 1 and `stall` = 1.
- Cycle 2: first WAIT cycle; rdy is ignored.
- Cycle k ≥ 3: rdy is seen at the edge ending cycle k, so WB (`wb_valid` = 1) occurs in cycle k+1, and IDLE with `stall` = 0 in cycle k+2.
- Minimum occupancy is 4 cycles. Timeout writeback occurs in cycle `TIMEOUT`+2.
- Back-to-back operations: a new start is accepted in the first IDLE cycle after WB.

## Test plan
- **Divide:** `start_div`, a=100, b=7, dest=5; the div model asserts rdy 33 cycles after the pulse with result 14 → `ctrl_DIV` high exactly in cycle 1, `stall` high in cycles 1 through WB, one `wb_valid` with reg 5 and data 14.
- **Divide by zero:** b=0 and the div model raises exception with rdy → `wb_reg`=30, `wb_data`=2; no write to dest.
- **Multiply:** a=−3, b=4, dest=7 → `ctrl_MULT` pulse with `ctrl_DIV`=0; writeback of reg 7 with data 0xFFFFFFF4. With `mult_exception` high instead → reg 30, data 1.
- **Stale rdy and timeout:** hold `div_rdy`=1 from the prior op through the first WAIT cycle and then never re-assert it → the stale rdy is ignored, and at `TIMEOUT` the block writes reg 30 with data 3.
- **Flush and reset mid-op:** `flush` in WAIT cycle 10 → IDLE next cycle, no `wb_valid` even if rdy arrives later. `reset`=0 mid-WAIT → all outputs 0 immediately, and the next start works normally.
- **dest=0 and simultaneous starts:** dest=0 with no exception → no `wb_valid` but normal `stall` timing. `start_mult` and `start_div` in the same cycle → only `ctrl_MULT` pulses. A start asserted during `stall` → ignored.
